mem_store_ctrl: RTL and testbench

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

---
 rtl/mem_store_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_store_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_ctrl.sv
// ---------------------------------------------------------------------------
// mem_store_ctrl
//
// Serialises a byte, halfword or word store into single-byte RAM writes,
// least significant byte first, at consecutive byte addresses. Bytes whose
// address falls in the memory-mapped I/O region are held back while the I/O
// sink reports it is full. A global enable freezes every register.
//
// Parameters
//   IO_BASE            lowest address of the memory-mapped I/O region
//
// Ports
//   clk_in             clock, all state changes on the rising edge
//   rst_in             asynchronous reset, active low
//   rdy_in             global enable, low freezes all state
//   store_valid_in     store request valid
//   store_addr_in      byte address of the first byte stored
//   store_data_in      store data, least significant byte first
//   store_size_in      00 byte, 01 halfword, 10/11 word
//   io_buffer_full_in  I/O sink cannot accept a byte this cycle
//   store_ready_out    block can accept a request (high in IDLE)
//   store_done_out     one-cycle pulse after the last byte is written
//   mem_dout           byte driven to RAM
//   mem_a              RAM byte address
//   mem_wr             RAM write strobe
// ---------------------------------------------------------------------------
module mem_store_ctrl #(
   parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        store_valid_in,
   input  logic [31:0] store_addr_in,
   input  logic [31:0] store_data_in,
   input  logic [1:0]  store_size_in,
   input  logic        io_buffer_full_in,
   output logic        store_ready_out,
   output logic        store_done_out,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_WRITE = 1'b1;

   logic [0:0]  state_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [2:0]  count_q;
   logic [1:0]  idx_q;
   logic        done_q;

   logic        in_write;
   logic [31:0] byte_addr;
   logic [7:0]  byte_data;
   logic        io_stall;
   logic        last_byte;
   logic [2:0]  req_count;

   // Number of bytes for the requested size; both 10 and 11 mean a word.
   always_comb begin
      req_count = 3'd4;
      case (store_size_in)
         2'b00:   req_count = 3'd1;
         2'b01:   req_count = 3'd2;
         default: req_count = 3'd4;
      endcase
   end

   // Current byte: the address wraps naturally at 2^32, so a store that
   // starts near the top of the address space continues at address zero.
   always_comb begin
      byte_addr = addr_q + {30'd0, idx_q};
      byte_data = data_q[7:0];
      case (idx_q)
         2'd0: byte_data = data_q[7:0];
         2'd1: byte_data = data_q[15:8];
         2'd2: byte_data = data_q[23:16];
         2'd3: byte_data = data_q[31:24];
         default: byte_data = data_q[7:0];
      endcase
      io_stall  = (byte_addr >= IO_BASE) && io_buffer_full_in;
      last_byte = ({1'b0, idx_q} == (count_q - 3'd1));
   end

   // Outputs are decoded from the registers; the bus is driven to zero
   // while idle so nothing stale leaks onto the RAM interface.
   always_comb begin
      in_write        = (state_q == S_WRITE);
      store_ready_out = !in_write;
      store_done_out  = done_q;
      mem_wr          = in_write && rdy_in && !io_stall;
      mem_a           = in_write ? byte_addr : 32'd0;
      mem_dout        = in_write ? byte_data : 8'd0;
   end

   // Request capture and byte sequencing. Nothing moves while rdy_in is
   // low, which also keeps a pending done pulse visible until the enable
   // returns. A byte only advances the index when the strobe actually fired.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         count_q <= 3'd1;
         idx_q   <= 2'd0;
         done_q  <= 1'b0;
      end else if (rdy_in) begin
         if (state_q == S_IDLE) begin
            done_q <= 1'b0;
            if (store_valid_in) begin
               addr_q  <= store_addr_in;
               data_q  <= store_data_in;
               count_q <= req_count;
               idx_q   <= 2'd0;
               state_q <= S_WRITE;
            end
         end else begin
            done_q <= 1'b0;
            if (mem_wr) begin
               if (last_byte) begin
                  state_q <= S_IDLE;
                  idx_q   <= 2'd0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_store_ctrl
//
// Self-checking bench for mem_store_ctrl. A queue-based model holds the bytes
// still owed for the current store; every cycle the DUT outputs are compared
// against the head of that queue. Directed tests add literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_store_ctrl;

   localparam logic [31:0] TB_IO_BASE = 32'h0003_0000;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        store_valid_in;
   logic [31:0] store_addr_in;
   logic [31:0] store_data_in;
   logic [1:0]  store_size_in;
   logic        io_buffer_full_in;
   logic        store_ready_out;
   logic        store_done_out;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   int checkCount = 0;
   int passCount  = 0;

   mem_store_ctrl #(.IO_BASE(TB_IO_BASE)) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .rdy_in            (rdy_in),
      .store_valid_in    (store_valid_in),
      .store_addr_in     (store_addr_in),
      .store_data_in     (store_data_in),
      .store_size_in     (store_size_in),
      .io_buffer_full_in (io_buffer_full_in),
      .store_ready_out   (store_ready_out),
      .store_done_out    (store_done_out),
      .mem_dout          (mem_dout),
      .mem_a             (mem_a),
      .mem_wr            (mem_wr)
   );

   // Free-running clock, 10 time units per period.
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Model: a store is simply the list of (address, byte) pairs still owed.
   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } byteT;

   byteT pendQ[$];
   logic doneExp = 1'b0;

   function automatic logic modelWr();
      if (pendQ.size() == 0) return 1'b0;
      if (!rdy_in) return 1'b0;
      if (pendQ[0].a >= TB_IO_BASE && io_buffer_full_in) return 1'b0;
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // Model update: reset empties the owed list; on an enabled edge an idle
   // model takes a new request, a busy one retires the head byte if written.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pendQ.delete();
         doneExp = 1'b0;
      end else if (rdy_in) begin
         logic nextDone;
         nextDone = 1'b0;
         if (pendQ.size() != 0) begin
            if (modelWr()) begin
               void'(pendQ.pop_front());
               if (pendQ.size() == 0) nextDone = 1'b1;
            end
         end else if (store_valid_in) begin
            int n;
            n = (store_size_in == 2'b00) ? 1 : (store_size_in == 2'b01) ? 2 : 4;
            for (int i = 0; i < n; i++) begin
               byteT b;
               b.a = store_addr_in + 32'(i);
               b.d = 8'(store_data_in >> (8 * i));
               pendQ.push_back(b);
            end
         end
         doneExp = nextDone;
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk_in) begin
      logic        busy;
      logic [31:0] expA;
      logic [7:0]  expD;
      busy = (pendQ.size() != 0);
      expA = busy ? pendQ[0].a : 32'd0;
      expD = busy ? pendQ[0].d : 8'd0;
      checkOutput("cyc_ready", {31'd0, store_ready_out}, {31'd0, !busy});
      checkOutput("cyc_wr",    {31'd0, mem_wr},          {31'd0, modelWr()});
      checkOutput("cyc_a",     mem_a,                    expA);
      checkOutput("cyc_dout",  {24'd0, mem_dout},        {24'd0, expD});
      checkOutput("cyc_done",  {31'd0, store_done_out},  {31'd0, doneExp});
   end

   task automatic nextCycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      store_addr_in  = addr;
      store_data_in  = data;
      store_size_in  = size;
      store_valid_in = 1'b1;
   endtask

   initial begin
      logic [7:0] wordBytes [4];
      wordBytes[0] = 8'hAA; wordBytes[1] = 8'hBB; wordBytes[2] = 8'hCC; wordBytes[3] = 8'hDD;

      rst_in = 1'b0; rdy_in = 1'b1; store_valid_in = 1'b0;
      store_addr_in = 32'd0; store_data_in = 32'd0; store_size_in = 2'b00;
      io_buffer_full_in = 1'b0;

      // Reset state
      #1;
      checkOutput("rst_ready", {31'd0, store_ready_out}, 32'd1);
      checkOutput("rst_wr",    {31'd0, mem_wr},          32'd0);
      checkOutput("rst_a",     mem_a,                    32'd0);
      checkOutput("rst_done",  {31'd0, store_done_out},  32'd0);
      repeat (2) nextCycle();
      rst_in = 1'b1;
      nextCycle();

      // Word store, four bytes then done
      applyStimulus(32'h0000_1000, 32'hDDCC_BBAA, 2'b10);
      nextCycle();
      store_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("word_a",    mem_a,              32'h0000_1000 + 32'(i));
         checkOutput("word_dout", {24'd0, mem_dout},  {24'd0, wordBytes[i]});
         checkOutput("word_wr",   {31'd0, mem_wr},    32'd1);
         nextCycle();
      end
      checkOutput("word_done",  {31'd0, store_done_out},  32'd1);
      checkOutput("word_ready", {31'd0, store_ready_out}, 32'd1);
      nextCycle();
      checkOutput("word_done_off", {31'd0, store_done_out}, 32'd0);

      // I/O stall: sink full for three cycles
      io_buffer_full_in = 1'b1;
      applyStimulus(32'h0003_0000, 32'h0000_0041, 2'b00);
      nextCycle();
      store_valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checkOutput("io_stall_wr", {31'd0, mem_wr}, 32'd0);
         checkOutput("io_stall_a",  mem_a,           32'h0003_0000);
         nextCycle();
      end
      io_buffer_full_in = 1'b0;
      #1;
      checkOutput("io_wr",   {31'd0, mem_wr},   32'd1);
      checkOutput("io_dout", {24'd0, mem_dout}, 32'h41);
      nextCycle();
      checkOutput("io_done", {31'd0, store_done_out}, 32'd1);
      nextCycle();

      // Halfword wrapping past the top of the address space
      applyStimulus(32'hFFFF_FFFF, 32'h0000_1234, 2'b01);
      nextCycle();
      store_valid_in = 1'b0;
      checkOutput("wrap_a0", mem_a,              32'hFFFF_FFFF);
      checkOutput("wrap_d0", {24'd0, mem_dout},  32'h34);
      nextCycle();
      checkOutput("wrap_a1", mem_a,              32'h0000_0000);
      checkOutput("wrap_d1", {24'd0, mem_dout},  32'h12);
      checkOutput("wrap_wr", {31'd0, mem_wr},    32'd1);
      nextCycle();
      checkOutput("wrap_done", {31'd0, store_done_out}, 32'd1);
      nextCycle();

      // Freeze for two cycles after the second byte
      applyStimulus(32'h0000_2000, 32'h4433_2211, 2'b11);
      nextCycle();
      store_valid_in = 1'b0;
      checkOutput("frz_d0", {24'd0, mem_dout}, 32'h11);
      nextCycle();
      checkOutput("frz_d1", {24'd0, mem_dout}, 32'h22);
      nextCycle();
      rdy_in = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checkOutput("frz_wr", {31'd0, mem_wr}, 32'd0);
         checkOutput("frz_a",  mem_a,           32'h0000_2002);
         nextCycle();
      end
      rdy_in = 1'b1;
      #1;
      checkOutput("frz_d2", {24'd0, mem_dout}, 32'h33);
      checkOutput("frz_wr2", {31'd0, mem_wr},  32'd1);
      nextCycle();
      checkOutput("frz_a3", mem_a,             32'h0000_2003);
      checkOutput("frz_d3", {24'd0, mem_dout}, 32'h44);
      nextCycle();
      checkOutput("frz_done", {31'd0, store_done_out}, 32'd1);
      nextCycle();

      // Reset mid-store, then the first request after release
      applyStimulus(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
      nextCycle();
      store_valid_in = 1'b0;
      nextCycle();
      nextCycle();
      rst_in = 1'b0;
      #1;
      checkOutput("rst_mid_wr",    {31'd0, mem_wr},          32'd0);
      checkOutput("rst_mid_ready", {31'd0, store_ready_out}, 32'd1);
      checkOutput("rst_mid_a",     mem_a,                    32'd0);
      nextCycle();
      rst_in = 1'b1;
      applyStimulus(32'h0000_0050, 32'h0000_007E, 2'b00);
      #1;
      checkOutput("rst_no_done", {31'd0, store_done_out}, 32'd0);
      nextCycle();
      store_valid_in = 1'b0;
      checkOutput("post_rst_wr",   {31'd0, mem_wr},         32'd1);
      checkOutput("post_rst_a",    mem_a,                   32'h0000_0050);
      checkOutput("post_rst_dout", {24'd0, mem_dout},       32'h7E);
      checkOutput("post_rst_done", {31'd0, store_done_out}, 32'd0);
      nextCycle();
      checkOutput("post_rst_done1", {31'd0, store_done_out}, 32'd1);
      nextCycle();
      checkOutput("no_resume_wr", {31'd0, mem_wr}, 32'd0);
      nextCycle();

      // Back-to-back: second request held valid through the done cycle
      applyStimulus(32'h0000_0100, 32'h0000_005A, 2'b00);
      nextCycle();
      applyStimulus(32'h0000_0104, 32'h0000_00A5, 2'b00);
      checkOutput("b2b_d0", {24'd0, mem_dout}, 32'h5A);
      nextCycle();
      checkOutput("b2b_done",  {31'd0, store_done_out},  32'd1);
      checkOutput("b2b_ready", {31'd0, store_ready_out}, 32'd1);
      nextCycle();
      store_valid_in = 1'b0;
      checkOutput("b2b_a1",  mem_a,             32'h0000_0104);
      checkOutput("b2b_d1",  {24'd0, mem_dout}, 32'hA5);
      checkOutput("b2b_wr1", {31'd0, mem_wr},   32'd1);
      nextCycle();
      checkOutput("b2b_done2", {31'd0, store_done_out}, 32'd1);
      nextCycle();

      // Done pulse held while the enable is low
      applyStimulus(32'h0000_0010, 32'h0000_0099, 2'b00);
      nextCycle();
      store_valid_in = 1'b0;
      nextCycle();
      rdy_in = 1'b0;
      #1;
      checkOutput("hold_done0", {31'd0, store_done_out}, 32'd1);
      nextCycle();
      checkOutput("hold_done1", {31'd0, store_done_out}, 32'd1);
      rdy_in = 1'b1;
      nextCycle();
      checkOutput("hold_done2", {31'd0, store_done_out}, 32'd0);
      nextCycle();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
